// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster timing bundle from vga_timing to the bit generator and DAC
interface vga_timing_if;
  logic        pixelEn;
  logic [15:0] hCount;
  logic [15:0] vCount;
  logic        bright;
  logic        hSync;
  logic        vSync;
  logic        frameStart;
  logic        vblank;

  modport master (
    output pixelEn, hCount, vCount, bright, hSync, vSync, frameStart, vblank
  );

  modport slave (
    input pixelEn, hCount, vCount, bright, hSync, vSync, frameStart, vblank
  );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 raster timing generator with pixel-rate divider
module vga_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master vga
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [15:0] H_LAST     = 16'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [15:0] V_LAST     = 16'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [15:0] H_VIS      = 16'(H_VISIBLE);
  localparam logic [15:0] H_SYNC_LO  = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] H_SYNC_HI  = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] V_VIS      = 16'(V_VISIBLE);
  localparam logic [15:0] V_SYNC_LO  = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] V_SYNC_HI  = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_FRONT,
    ST_SYNC,
    ST_BACK
  } vstate_t;

  vstate_t          vState;
  vstate_t          vStateNext;
  logic [DIV_W-1:0] divCount;
  logic [DIV_W-1:0] divNext;
  logic [15:0]      hNext;
  logic [15:0]      vNext;
  logic             lineEnd;

  // Everything registered below is decoded from the next-state counts so
  // hSync/bright/vSync line up with the hCount/vCount they describe.
  always_comb begin
    divNext    = (divCount == DIV_LAST) ? '0 : divCount + 1'b1;
    lineEnd    = vga.pixelEn && (vga.hCount == H_LAST);
    hNext      = vga.hCount;
    vNext      = vga.vCount;
    vStateNext = vState;
    if (vga.pixelEn) begin
      hNext = (vga.hCount == H_LAST) ? 16'd0 : vga.hCount + 16'd1;
    end
    if (lineEnd) begin
      vNext = (vga.vCount == V_LAST) ? 16'd0 : vga.vCount + 16'd1;
      case (vState)
        ST_ACTIVE: if (vNext == V_VIS)     vStateNext = ST_FRONT;
        ST_FRONT:  if (vNext == V_SYNC_LO) vStateNext = ST_SYNC;
        ST_SYNC:   if (vNext == V_SYNC_HI) vStateNext = ST_BACK;
        ST_BACK:   if (vNext == 16'd0)     vStateNext = ST_ACTIVE;
        default:                           vStateNext = ST_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCount       <= '0;
      vState         <= ST_ACTIVE;
      vga.pixelEn    <= 1'b0;
      vga.hCount     <= 16'd0;
      vga.vCount     <= 16'd0;
      vga.bright     <= 1'b0;
      vga.hSync      <= 1'b1;
      vga.vSync      <= 1'b1;
      vga.frameStart <= 1'b0;
      vga.vblank     <= 1'b0;
    end else begin
      divCount       <= divNext;
      vState         <= vStateNext;
      vga.pixelEn    <= (divCount == DIV_LAST);
      vga.hCount     <= hNext;
      vga.vCount     <= vNext;
      vga.bright     <= (hNext < H_VIS) && (vNext < V_VIS);
      vga.hSync      <= !((hNext >= H_SYNC_LO) && (hNext < H_SYNC_HI));
      vga.vSync      <= (vStateNext != ST_SYNC);
      vga.vblank     <= (vStateNext != ST_ACTIVE);
      vga.frameStart <= lineEnd && (vga.vCount == V_LAST);
    end
  end
endmodule
